matrix_anim_player: RTL and testbench
=====================================

// Module: matrix_anim_player
// PURPOSE
//  Parametrised dual-colour (red/green) LED dot-matrix driver with a writable frame store.
//  Plays frame sequences in four modes: static, play-once, loop and blink.
//  Scans rows active-low and drives the red/green column buses for the row being scanned.
//  Game control logic loads frames and selects sequences; the block replaces per-state hard-coded pictures.
// PARAMETERS
//  ROWS     8   matrix rows; row scan width
//  COLS     8   matrix columns; red/green width
//  FRAMES   16  frame-store depth in frames (power of 2); FW = clog2(FRAMES)
//  TICK_W   21  width of hold_ticks and the frame-hold counter
//  SCAN_DIV 1   clk cycles spent on each row (>=1)
// PORTS
//  clk         in   1         system clock, the only clock
//  rst         in   1         synchronous reset, active-high
//  en          in   1         display enable; 0 blanks red/green (the sw7-style master switch)
//  wr_en       in   1         frame-store write strobe
//  wr_frame    in   FW        frame index to write
//  wr_row      in   clog2(ROWS) row index to write
//  wr_red      in   COLS      red pattern for that row
//  wr_green    in   COLS      green pattern for that row
//  start       in   1         1-cycle pulse: latch mode/first/last/hold and begin playback
//  mode        in   2         0 STATIC, 1 ONCE, 2 LOOP, 3 BLINK
//  first_frame in   FW        first frame of the sequence
//  last_frame  in   FW        last frame of the sequence
//  hold_ticks  in   TICK_W    clk cycles each frame is shown
//  stop        in   1         abort playback and return to IDLE (display blank)
//  row         out  ROWS      active-low one-hot row select
//  red         out  COLS      red columns for the current row (1 = lit)
//  green       out  COLS      green columns for the current row
//  cur_frame   out  FW        frame index being displayed
//  busy        out  1         high in PLAY/BLINK_ON/BLINK_OFF
//  done        out  1         1-cycle pulse when ONCE finishes its last frame
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): row=all 1s, red=green=0, cur_frame=0, busy=0, done=0,
//    state=IDLE, scan_idx=0, hold counter=0. The frame store is NOT cleared.
//  Scan:
//    - scan_idx advances every SCAN_DIV cycles and wraps from ROWS-1 to 0.
//    - It runs regardless of en or state.
//    - row, red and green are registered and change on the same edge, so the colour data always matches the selected row.
//  Data:
//    - red/green = store[cur_frame][scan_idx] when en=1 and state is PLAY, HOLD or BLINK_ON; otherwise 0.
//    - Exception: with en=0, row keeps scanning and red/green = 0.
//  Writes:
//    - Take effect on the edge where wr_en=1.
//    - A read of the same frame/row on a later cycle returns the new data; no bypass within the same cycle.
//  FSM states: IDLE, PLAY, HOLD, BLINK_ON, BLINK_OFF.
//    - start in any state latches the inputs, sets cur_frame=first_frame, clears the hold counter, then:
//      STATIC/ONCE/LOOP -> PLAY; BLINK -> BLINK_ON. start while busy restarts playback.
//    - PLAY: the counter counts to hold_ticks-1, then the frame advances:
//      STATIC: stays on first_frame indefinitely and never advances.
//      ONCE: cur_frame+1 until last_frame; after last_frame's hold -> HOLD with done=1 for 1 cycle.
//      LOOP: after last_frame wraps to first_frame, endlessly.
//    - HOLD: last frame stays displayed, busy=0, until start, stop or rst.
//    - BLINK_ON/BLINK_OFF: toggle every hold_ticks cycles; ON shows first_frame, OFF shows blank.
//    - stop takes effect from any state -> IDLE, busy=0, cur_frame unchanged.
//    - Priority: rst > stop > start.
//  Boundaries:
//    - hold_ticks=0 is treated as 1.
//    - last_frame<first_frame: sequence is first_frame only (ONCE gives done after one hold).
//    - Frame increment wraps modulo FRAMES.
//    - The hold counter saturates and never wraps mid-frame.
// TESTING
//  T1 rst held 3 cycles -> row=8'hFF, red=green=0, busy=0; release -> row walks FE,FD,...,7F,FE (SCAN_DIV=1).
//  T2 write frame 2 = bomb pattern; start mode=0 first=2 -> row FE shows red=8'h18 on the same cycle; en=0 -> red=green=0 while row keeps scanning.
//  T3 mode=1 first=0 last=3 hold=4 -> cur_frame 0,1,2,3 at 4-cycle steps; done=1 exactly 1 cycle at the end; cur_frame holds 3; busy=0.
//  T4 mode=2 first=5 last=6 hold=2 -> cur_frame 5,5,6,6,5,5,...; start mid-frame with first=1 -> cur_frame=1 on the next cycle, hold counter restarted.
//  T5 mode=3 first=4 hold=3 -> 3 cycles of frame 4 data, then 3 cycles of red=green=0, repeating; stop -> IDLE, blank.
//  T6 hold=0 and last<first (first=7,last=2, ONCE) -> a single 1-cycle hold of frame 7, then done; a write to the displayed row appears on its next scan.

Source files
------------

// File: rtl/matrix_anim_player.sv
// Dual-colour LED dot-matrix driver: frame store, row scanner and static/once/loop/blink sequencer.
// Latency: row/red/green are registered one cycle after scan_idx/cur_frame/state; writes are visible from the next cycle.
// Backpressure: none; writes and start/stop are accepted every cycle, and scanning never stalls.
module matrix_anim_player #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int FRAMES   = 16,
   parameter int TICK_W   = 21,
   parameter int SCAN_DIV = 1,
   localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr_en,
   input  logic [FW-1:0]     wr_frame,
   input  logic [RW-1:0]     wr_row,
   input  logic [COLS-1:0]   wr_red,
   input  logic [COLS-1:0]   wr_green,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [FW-1:0]     first_frame,
   input  logic [FW-1:0]     last_frame,
   input  logic [TICK_W-1:0] hold_ticks,
   input  logic              stop,
   output logic [ROWS-1:0]   row,
   output logic [COLS-1:0]   red,
   output logic [COLS-1:0]   green,
   output logic [FW-1:0]     cur_frame,
   output logic              busy,
   output logic              done
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PLAY      = 3'd1;
   localparam logic [2:0] S_HOLD      = 3'd2;
   localparam logic [2:0] S_BLINK_ON  = 3'd3;
   localparam logic [2:0] S_BLINK_OFF = 3'd4;

   localparam logic [1:0] M_STATIC = 2'd0;
   localparam logic [1:0] M_LOOP   = 2'd2;
   localparam logic [1:0] M_BLINK  = 2'd3;

   logic [COLS-1:0]   red_mem   [FRAMES][ROWS];
   logic [COLS-1:0]   green_mem [FRAMES][ROWS];

   logic [2:0]        state;
   logic [1:0]        mode_q;
   logic [FW-1:0]     first_q;
   logic [FW-1:0]     last_q;
   logic [FW-1:0]     cur_q;
   logic [TICK_W-1:0] hold_q;
   logic [TICK_W-1:0] hold_cnt;
   logic [RW-1:0]     scan_idx;
   logic [DW-1:0]     div_cnt;
   logic              done_q;
   logic [ROWS-1:0]   row_q;
   logic [COLS-1:0]   red_q;
   logic [COLS-1:0]   green_q;

   logic              hold_end;
   logic              seq_end;
   logic              show;

   // hold_q is never 0 (zero is latched as 1), so hold_q-1 cannot underflow;
   // the >= compare keeps the counter pinned at hold_q-1 once reached (saturation)
   assign hold_end = (hold_cnt >= (hold_q - TICK_W'(1)));
   // a reversed range collapses the sequence to first_frame alone
   assign seq_end  = (cur_q == last_q) || (last_q < first_q);
   assign show     = en && ((state == S_PLAY) || (state == S_HOLD) || (state == S_BLINK_ON));

   assign busy      = (state == S_PLAY) || (state == S_BLINK_ON) || (state == S_BLINK_OFF);
   assign done      = done_q;
   assign cur_frame = cur_q;
   assign row       = row_q;
   assign red       = red_q;
   assign green     = green_q;

   // Frame store write port; deliberately untouched by reset so loaded pictures survive it
   always_ff @(posedge clk) begin
      if (wr_en) begin
         red_mem[wr_frame][wr_row]   <= wr_red;
         green_mem[wr_frame][wr_row] <= wr_green;
      end
   end

   // Row scanner: advance scan_idx every SCAN_DIV cycles, independent of en and state
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         scan_idx <= '0;
      end else if (div_cnt == DW'(SCAN_DIV - 1)) begin
         div_cnt  <= '0;
         scan_idx <= (scan_idx == RW'(ROWS - 1)) ? '0 : scan_idx + RW'(1);
      end else begin
         div_cnt  <= div_cnt + DW'(1);
      end
   end

   // Playback sequencer: stop beats start, start restarts from any state
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         mode_q   <= M_STATIC;
         first_q  <= '0;
         last_q   <= '0;
         hold_q   <= TICK_W'(1);
         cur_q    <= '0;
         hold_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (stop) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
         end else if (start) begin
            mode_q   <= mode;
            first_q  <= first_frame;
            last_q   <= last_frame;
            hold_q   <= (hold_ticks == '0) ? TICK_W'(1) : hold_ticks;
            cur_q    <= first_frame;
            hold_cnt <= '0;
            state    <= (mode == M_BLINK) ? S_BLINK_ON : S_PLAY;
         end else begin
            case (state)
               S_PLAY: begin
                  if (!hold_end) begin
                     hold_cnt <= hold_cnt + TICK_W'(1);
                  end else if (mode_q != M_STATIC) begin
                     hold_cnt <= '0;
                     if (!seq_end) begin
                        cur_q <= cur_q + FW'(1);
                     end else if (mode_q == M_LOOP) begin
                        cur_q <= first_q;
                     end else begin
                        state  <= S_HOLD;
                        done_q <= 1'b1;
                     end
                  end
               end
               S_BLINK_ON, S_BLINK_OFF: begin
                  if (!hold_end) begin
                     hold_cnt <= hold_cnt + TICK_W'(1);
                  end else begin
                     hold_cnt <= '0;
                     state    <= (state == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Output register: row select and colour data are loaded together so they always agree
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q   <= '1;
         red_q   <= '0;
         green_q <= '0;
      end else begin
         row_q   <= ~(ROWS'(1) << scan_idx);
         red_q   <= show ? red_mem[cur_q][scan_idx]   : '0;
         green_q <= show ? green_mem[cur_q][scan_idx] : '0;
      end
   end

endmodule

// File: tb/tb_matrix_anim_player.sv
// Directed bench for matrix_anim_player with default parameters (8x8, 16 frames, SCAN_DIV=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values come from hand-written constants and a bench-side copy of the frame store.
module tb_matrix_anim_player;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_frame = '0;
   logic [2:0]  wr_row = '0;
   logic [7:0]  wr_red = '0;
   logic [7:0]  wr_green = '0;
   logic        start = 1'b0;
   logic [1:0]  mode = '0;
   logic [3:0]  first_frame = '0;
   logic [3:0]  last_frame = '0;
   logic [20:0] hold_ticks = '0;
   logic        stop = 1'b0;
   logic [7:0]  row;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [3:0]  cur_frame;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int scan_m = 0;   // scan index the DUT will use at the next edge
   int shown  = 0;   // scan index loaded into the outputs at the last edge

   logic [7:0] m_red   [16][8];
   logic [7:0] m_green [16][8];
   logic [7:0] bomb_r [8] = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18};
   logic [7:0] bomb_g [8] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] onehot;

   matrix_anim_player dut (
      .clk(clk), .rst(rst), .en(en),
      .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_red(wr_red), .wr_green(wr_green),
      .start(start), .mode(mode), .first_frame(first_frame), .last_frame(last_frame),
      .hold_ticks(hold_ticks), .stop(stop),
      .row(row), .red(red), .green(green), .cur_frame(cur_frame), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) begin
         scan_m = 0;
      end else begin
         shown  = scan_m;
         scan_m = (scan_m + 1) % 8;
      end
   endtask

   function automatic logic [7:0] exp_row(input int idx);
      logic [7:0] one;
      one = 8'h01 << idx;
      return ~one;
   endfunction

   task automatic write_row(input int f, input int r, input logic [7:0] rd, input logic [7:0] gr);
      wr_en    = 1'b1;
      wr_frame = 4'(f);
      wr_row   = 3'(r);
      wr_red   = rd;
      wr_green = gr;
      m_red[f][r]   = rd;
      m_green[f][r] = gr;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_start(input logic [1:0] md, input int f, input int l, input int h);
      start       = 1'b1;
      mode        = md;
      first_frame = 4'(f);
      last_frame  = 4'(l);
      hold_ticks  = 21'(h);
      tick();
      start = 1'b0;
   endtask

   initial begin
      // T1: reset state, then the row walk
      repeat (3) tick();
      check("rst_row", row, 8'hFF);
      check("rst_red", red, 8'h00);
      check("rst_green", green, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cur", cur_frame, 4'h0);
      rst = 1'b0;
      tick();
      check("walk_first", row, 8'hFE);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("walk_%0d", i), row, exp_row(i % 8));
      end
      check("idle_blank", red, 8'h00);

      // Load every frame; frame 2 is the bomb picture
      for (int f = 0; f < 16; f++) begin
         for (int r = 0; r < 8; r++) begin
            if (f == 2) write_row(f, r, bomb_r[r], bomb_g[r]);
            else        write_row(f, r, 8'(f * 16 + r * 2 + 1), ~8'(f * 16 + r * 2 + 1));
         end
      end

      // T2: static bomb, then en=0 blanking while rows keep scanning
      do_start(2'd0, 2, 2, 5);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (row == 8'hFE) break;
      end
      check("t2_row_fe", row, 8'hFE);
      check("t2_red_fe", red, 8'h18);
      check("t2_green_fe", green, 8'h20);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("t2_red_r%0d", shown), red, bomb_r[shown]);
      end
      repeat (12) tick();
      check("t2_static_cur", cur_frame, 4'h2);
      check("t2_busy", busy, 1'b1);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_en0_row", row, exp_row(shown));
         check("t2_en0_red", red, 8'h00);
         check("t2_en0_green", green, 8'h00);
      end
      en = 1'b1;

      // T3: play-once 0..3, hold 4
      do_start(2'd1, 0, 3, 4);
      check("t3_cur_start", cur_frame, 4'h0);
      for (int k = 1; k < 16; k++) begin
         tick();
         check($sformatf("t3_cur_%0d", k), cur_frame, 32'(k / 4));
         check($sformatf("t3_done_%0d", k), done, 1'b0);
         check($sformatf("t3_busy_%0d", k), busy, 1'b1);
      end
      tick();
      check("t3_done_pulse", done, 1'b1);
      check("t3_cur_end", cur_frame, 4'h3);
      check("t3_busy_end", busy, 1'b0);
      tick();
      check("t3_done_clear", done, 1'b0);
      check("t3_cur_hold", cur_frame, 4'h3);
      check("t3_hold_red", red, m_red[3][shown]);

      // T4: loop 5..6 hold 2, then a mid-frame restart at frame 1
      do_start(2'd2, 5, 6, 2);
      check("t4_cur_0", cur_frame, 4'h5);
      for (int k = 1; k < 8; k++) begin
         tick();
         check($sformatf("t4_cur_%0d", k), cur_frame, ((k / 2) % 2 == 1) ? 32'd6 : 32'd5);
      end
      do_start(2'd2, 1, 6, 2);
      check("t4_restart", cur_frame, 4'h1);
      tick();
      check("t4_restart_hold", cur_frame, 4'h1);
      tick();
      check("t4_restart_adv", cur_frame, 4'h2);

      // T5: blink frame 4 hold 3, then stop
      do_start(2'd3, 4, 4, 3);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (((k - 1) / 3) % 2 == 0) begin
            check($sformatf("t5_on_red_%0d", k), red, m_red[4][shown]);
            check($sformatf("t5_on_green_%0d", k), green, m_green[4][shown]);
         end else begin
            check($sformatf("t5_off_red_%0d", k), red, 8'h00);
            check($sformatf("t5_off_green_%0d", k), green, 8'h00);
         end
         check($sformatf("t5_busy_%0d", k), busy, 1'b1);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t5_stop_busy", busy, 1'b0);
      check("t5_stop_cur", cur_frame, 4'h4);
      tick();
      check("t5_stop_red", red, 8'h00);
      check("t5_stop_green", green, 8'h00);

      // T6: hold=0 with a reversed range, then a live write to the displayed frame
      do_start(2'd1, 7, 2, 0);
      check("t6_cur", cur_frame, 4'h7);
      check("t6_busy", busy, 1'b1);
      check("t6_no_done", done, 1'b0);
      tick();
      check("t6_done", done, 1'b1);
      check("t6_busy_end", busy, 1'b0);
      check("t6_cur_end", cur_frame, 4'h7);
      tick();
      check("t6_done_clear", done, 1'b0);
      check("t6_hold_red", red, m_red[7][shown]);
      write_row(7, 3, 8'hA5, 8'h5A);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (shown == 3) break;
      end
      check("t6_wr_row", row, 8'hF7);
      check("t6_wr_red", red, 8'hA5);
      check("t6_wr_green", green, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
